inc_arbiter: RTL and testbench

INC_ARBITER -- requirements
Module: inc_arbiter

---
 rtl/inc_arbiter.sv | 128 ++++++++++++
 tb/tb_inc_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inc_arbiter.sv
// Two-requester round-robin front end for a single shared external +1 unit.
// Each operation runs IDLE -> ISSUE -> DONE, so one increment completes every three cycles.
module inc_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] in0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] inc_in,
    input  logic [WIDTH-1:0] inc_out,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             src,
    output logic             wrap,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             own_q, own_d;
    logic             last_src_q, last_src_d;
    logic             src_q, src_d;
    logic             wrap_q, wrap_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             valid_q, valid_d;
    logic             win;

    // The winner is held in own_q while the operation runs. src only moves
    // when result is captured, so src, result and wrap always describe the
    // same completed operation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        result_d   = result_q;
        own_d      = own_q;
        last_src_d = last_src_q;
        src_d      = src_q;
        wrap_d     = wrap_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        valid_d    = 1'b0;
        win        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win     = (req0 && req1) ? ~last_src_q : req1;
                    op_d    = win ? in1 : in0;
                    own_d   = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                result_d = inc_out;
                wrap_d   = &op_q;
                src_d    = own_q;
                valid_d  = 1'b1;
                ack0_d   = ~own_q;
                ack1_d   = own_q;
                state_d  = DONE;
            end
            DONE: begin
                last_src_d = src_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            result_q   <= '0;
            own_q      <= 1'b0;
            last_src_q <= 1'b1;
            src_q      <= 1'b0;
            wrap_q     <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            result_q   <= result_d;
            own_q      <= own_d;
            last_src_q <= last_src_d;
            src_q      <= src_d;
            wrap_q     <= wrap_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            valid_q    <= valid_d;
        end
    end

    assign inc_in = op_q;
    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign result = result_q;
    assign valid  = valid_q;
    assign src    = src_q;
    assign wrap   = wrap_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_inc_arbiter.sv
// Directed bench for inc_arbiter; the external +1 unit is modelled combinationally.
module tb_inc_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] in0, in1;
    logic [7:0] inc_in, inc_out;
    logic       gnt0, gnt1, ack0, ack1, valid, src, wrap, busy;
    logic [7:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign inc_out = inc_in + 8'd1;

    inc_arbiter #(.WIDTH(8)) dut (
        .clock  (clk),
        .reset  (reset),
        .req0   (req0),
        .in0    (in0),
        .req1   (req1),
        .in1    (in1),
        .inc_in (inc_in),
        .inc_out(inc_out),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .ack0   (ack0),
        .ack1   (ack1),
        .result (result),
        .valid  (valid),
        .src    (src),
        .wrap   (wrap),
        .busy   (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; in0 = '0; in1 = '0;

        // Reset state and quiet idle
        do_reset();
        chk("rst_gnt",    {gnt0, gnt1}, 2'b00);
        chk("rst_ack",    {ack0, ack1}, 2'b00);
        chk("rst_valid",  valid, 1'b0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_wrap",   wrap, 1'b0);
        chk("rst_src",    src, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_inc_in", inc_in, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_quiet", {gnt0, gnt1, ack0, ack1, valid, busy}, 6'b0);
        end

        // Single requester 0, operand change after latching ignored
        req0 = 1'b1; in0 = 8'h3C;
        step();
        chk("r0_gnt",    {gnt0, gnt1}, 2'b10);
        chk("r0_inc_in", inc_in, 8'h3C);
        chk("r0_busy",   busy, 1'b1);
        chk("r0_novalid", valid, 1'b0);
        in0 = 8'hAA;
        step();
        chk("r0_valid",  valid, 1'b1);
        chk("r0_ack",    {ack0, ack1}, 2'b10);
        chk("r0_result", result, 8'h3D);
        chk("r0_src",    src, 1'b0);
        chk("r0_wrap",   wrap, 1'b0);
        chk("r0_gnt_off", {gnt0, gnt1}, 2'b00);
        req0 = 1'b0;
        step();
        chk("r0_strobe_off", {valid, ack0, busy}, 3'b000);
        chk("r0_hold",   result, 8'h3D);

        // Tie after reset: requester 0 first, then requester 1
        do_reset();
        req0 = 1'b1; req1 = 1'b1; in0 = 8'h10; in1 = 8'h20;
        step();
        chk("tie1_gnt", {gnt0, gnt1}, 2'b10);
        step();
        chk("tie1_result", result, 8'h11);
        chk("tie1_src",    src, 1'b0);
        chk("tie1_ack",    {ack0, ack1}, 2'b10);
        req0 = 1'b0;
        step();
        step();
        chk("tie2_gnt",    {gnt0, gnt1}, 2'b01);
        chk("tie2_inc_in", inc_in, 8'h20);
        step();
        chk("tie2_result", result, 8'h21);
        chk("tie2_src",    src, 1'b1);
        chk("tie2_ack",    {ack0, ack1}, 2'b01);
        req1 = 1'b0;
        step();

        // Wrap on all-ones, then a non-wrapping op clears wrap
        req1 = 1'b1; in1 = 8'hFF;
        step();
        step();
        chk("wrap_result", result, 8'h00);
        chk("wrap_flag",   wrap, 1'b1);
        chk("wrap_src",    src, 1'b1);
        chk("wrap_ack",    {ack0, ack1}, 2'b01);
        req1 = 1'b0; req0 = 1'b1; in0 = 8'h05;
        step();
        chk("wrap_hold",   {wrap, result}, {1'b1, 8'h00});
        step();
        step();
        chk("nowrap_result", result, 8'h06);
        chk("nowrap_flag",   wrap, 1'b0);
        chk("nowrap_src",    src, 1'b0);
        req0 = 1'b0;
        step();

        // Continuous contention: strict alternation, never two grants
        do_reset();
        req0 = 1'b1; req1 = 1'b1; in0 = 8'h40; in1 = 8'h50;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_gnt", {gnt0, gnt1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            step();
            chk("rr_src",    src, (k % 2 == 0) ? 1'b0 : 1'b1);
            chk("rr_result", result, (k % 2 == 0) ? 8'h41 : 8'h51);
            chk("rr_ack",    {ack0, ack1, valid}, (k % 2 == 0) ? 3'b101 : 3'b011);
            chk("rr_gnt_off", {gnt0, gnt1}, 2'b00);
            step();
            chk("rr_idle", busy, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset during ISSUE aborts; re-request completes
        do_reset();
        req0 = 1'b1; in0 = 8'h7F;
        step();
        chk("abort_gnt", {gnt0, gnt1}, 2'b10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_strobe", {valid, ack0, ack1, gnt0, busy}, 5'b0);
        chk("abort_result", result, 8'h00);
        step();
        chk("retry_gnt", {gnt0, gnt1}, 2'b10);
        step();
        chk("retry_result", result, 8'h80);
        chk("retry_valid",  {valid, ack0, wrap}, 3'b110);
        req0 = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
